// File: rtl/timer_ctrl.sv
// timer_ctrl: mode controller for the Basys3 countdown timer.
// Sequences IDLE / SET_MIN / SET_SEC / RUN / PAUSE / ALARM from the gesture
// pulses, owns the BCD minute/second and preset registers, the 1 Hz prescaler
// and the free-running blink square wave.
// Optional build macro: ALARM_AUTOCLR_EN -- when defined, ALARM returns to
// IDLE by itself after ALARM_SEC countdown seconds; otherwise ALARM persists
// until a gesture or a btn_long rising edge.
module timer_ctrl #(
  parameter int TICK_DIV  = 100000000,
  parameter int ALARM_SEC = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flag_short,
  input  logic       flag_long,
  input  logic       flag_double,
  input  logic       flag_triple,
  input  logic       flag_four,
  input  logic       btn_long,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [2:0] state,
  output logic       running,
  output logic       alarm,
  output logic       blink,
  output logic       sec_tick
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SET_MIN = 3'd1,
    SET_SEC = 3'd2,
    RUN     = 3'd3,
    PAUSE   = 3'd4,
    ALARM   = 3'd5
  } state_t;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam int HALF = (TICK_DIV / 2 > 0) ? TICK_DIV / 2 : 1;
  localparam int BW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [BW-1:0] BLINK_MAX = BW'(HALF - 1);

  // Elaboration-time sanity checks on the parameters.
  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("timer_ctrl: TICK_DIV must be at least 2");
  end
  if (ALARM_SEC < 1) begin : g_bad_alarm_sec
    $error("timer_ctrl: ALARM_SEC must be at least 1");
  end

  // BCD increment with wrap from top back to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    logic [7:0] r;
    if (v == top)               r = 8'h00;
    else if (v[3:0] == 4'd9)    r = {v[7:4] + 4'd1, 4'd0};
    else                        r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // BCD decrement with wrap from 00 up to top.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] top);
    logic [7:0] r;
    if (v == 8'h00)             r = top;
    else if (v[3:0] == 4'd0)    r = {v[7:4] - 4'd1, 4'd9};
    else                        r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  // One countdown second on {min, sec}; sec borrows from min at 00.
  function automatic logic [15:0] time_dec(input logic [15:0] t);
    logic [15:0] r;
    if (t[7:0] == 8'h00) r = {bcd_dec(t[15:8], 8'h99), 8'h59};
    else                 r = {t[15:8], bcd_dec(t[7:0], 8'h59)};
    return r;
  endfunction

  state_t          cur, nxt;
  logic [7:0]      min_q, sec_q, min_n, sec_n;
  logic [15:0]     pre_q, pre_n;
  logic [PW-1:0]   presc_q, presc_n;
  logic [BW-1:0]   blink_cnt;
  logic            btn_q;
  logic            hard_clr, tick, time_nz, dec_zero, any_flag;
  logic            p_four, p_triple, p_double, p_long, p_short;
  logic [15:0]     dec_t;
`ifdef ALARM_AUTOCLR_EN
  localparam int AW = (ALARM_SEC > 1) ? $clog2(ALARM_SEC + 1) : 1;
  localparam logic [AW-1:0] ACNT_LAST = AW'(ALARM_SEC - 1);
  logic [AW-1:0]   acnt_q, acnt_n;
`endif

  // Only the highest-priority gesture of a cycle is acted upon.
  assign p_four   = flag_four;
  assign p_triple = flag_triple & ~flag_four;
  assign p_double = flag_double & ~flag_triple & ~flag_four;
  assign p_long   = flag_long & ~flag_double & ~flag_triple & ~flag_four;
  assign p_short  = flag_short & ~flag_long & ~flag_double & ~flag_triple & ~flag_four;
  assign any_flag = flag_four | flag_triple | flag_double | flag_long | flag_short;

  assign hard_clr = btn_long & ~btn_q;
  assign tick     = (presc_q == PRESC_MAX);
  assign time_nz  = ({min_q, sec_q} != 16'h0000);
  assign dec_t    = time_dec({min_q, sec_q});
  assign dec_zero = (dec_t == 16'h0000);

  assign min_bcd  = min_q;
  assign sec_bcd  = sec_q;
  assign state    = cur;
  assign running  = (cur == RUN);
  assign alarm    = (cur == ALARM);
  assign sec_tick = (cur == RUN) && tick;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= IDLE;
    else       cur <= nxt;
  end

  // Next-state, time, preset and prescaler decisions; hard clear overrides all.
  always_comb begin
    nxt     = cur;
    min_n   = min_q;
    sec_n   = sec_q;
    pre_n   = pre_q;
    presc_n = '0;
`ifdef ALARM_AUTOCLR_EN
    acnt_n  = '0;
`endif
    case (cur)
      IDLE: begin
        if (p_four) begin
          min_n = 8'h00;
          sec_n = 8'h00;
        end else if (p_double) begin
          nxt = SET_MIN;
        end else if (p_short && time_nz) begin
          nxt   = RUN;
          pre_n = {min_q, sec_q};
        end
      end
      SET_MIN: begin
        if (p_triple)      nxt   = IDLE;
        else if (p_double) nxt   = SET_SEC;
        else if (p_long)   min_n = bcd_dec(min_q, 8'h99);
        else if (p_short)  min_n = bcd_inc(min_q, 8'h99);
      end
      SET_SEC: begin
        if (p_triple)      nxt   = IDLE;
        else if (p_double) nxt   = SET_MIN;
        else if (p_long)   sec_n = bcd_dec(sec_q, 8'h59);
        else if (p_short)  sec_n = bcd_inc(sec_q, 8'h59);
      end
      RUN: begin
        presc_n = tick ? '0 : presc_q + 1'b1;
        if (p_four) begin
          nxt            = IDLE;
          {min_n, sec_n} = pre_q;
        end else begin
          if (tick) begin
            {min_n, sec_n} = dec_t;
            if (dec_zero) nxt = ALARM;
          end
          // Reaching 00:00 beats a simultaneous pause request.
          if (p_short && !(tick && dec_zero)) nxt = PAUSE;
        end
      end
      PAUSE: begin
        presc_n = presc_q;
        if (p_four) begin
          nxt            = IDLE;
          {min_n, sec_n} = pre_q;
        end else if (p_triple) begin
          nxt = IDLE;
        end else if (p_short) begin
          nxt = RUN;
        end
      end
      ALARM: begin
`ifdef ALARM_AUTOCLR_EN
        presc_n = tick ? '0 : presc_q + 1'b1;
        acnt_n  = tick ? acnt_q + 1'b1 : acnt_q;
`endif
        if (any_flag) begin
          nxt            = IDLE;
          {min_n, sec_n} = pre_q;
        end
`ifdef ALARM_AUTOCLR_EN
        else if (tick && acnt_q == ACNT_LAST) begin
          nxt            = IDLE;
          {min_n, sec_n} = pre_q;
        end
`endif
      end
      default: nxt = IDLE;
    endcase
    if (hard_clr) begin
      nxt     = IDLE;
      min_n   = 8'h00;
      sec_n   = 8'h00;
      pre_n   = 16'h0000;
      presc_n = '0;
`ifdef ALARM_AUTOCLR_EN
      acnt_n  = '0;
`endif
    end
  end

  // Time, preset, prescaler and btn_long edge-detect registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      min_q   <= 8'h00;
      sec_q   <= 8'h00;
      pre_q   <= 16'h0000;
      presc_q <= '0;
      btn_q   <= 1'b0;
`ifdef ALARM_AUTOCLR_EN
      acnt_q  <= '0;
`endif
    end else begin
      min_q   <= min_n;
      sec_q   <= sec_n;
      pre_q   <= pre_n;
      presc_q <= presc_n;
      btn_q   <= btn_long;
`ifdef ALARM_AUTOCLR_EN
      acnt_q  <= acnt_n;
`endif
    end
  end

  // Free-running blink: toggles every TICK_DIV/2 cycles in every state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (blink_cnt == BLINK_MAX) begin
      blink_cnt <= '0;
      blink     <= ~blink;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

endmodule
